// File: rtl/div_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_mon_pkg
// Purpose  : Shared state type, default counter width and duty-match helper
//            for the divided-clock ratio monitor.
// Revision : 1.0 - initial release
// ============================================================================
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } div_mon_state_e;

    localparam int DEF_CNT_W = 8;

    // Odd ratios cannot split evenly, so either neighbour of ratio/2 is accepted.
    function automatic logic duty_match(input int unsigned high, input int unsigned ratio);
        if ((ratio % 2) == 0) begin
            return (high == ratio / 2);
        end
        return (high == ratio / 2) || (high == ratio / 2 + 1);
    endfunction

endpackage : div_mon_pkg
`default_nettype wire

// File: rtl/div_ratio_monitor_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Purpose  : Two-flop sampler for the divided clock with a registered rise
//            pulse and a level output aligned to that pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic lvl_o
);

    logic r_s1;
    logic r_s2;
    logic r_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= d_i;
            r_s2   <= r_s1;
            r_rise <= r_s1 & ~r_s2;
        end
    end

    assign rise_o = r_rise;
    // The rise pulse lags s1 by one cycle, so s2 is the level that lines up with it.
    assign lvl_o  = r_s2;

endmodule : rise_detect
`default_nettype wire

// File: rtl/div_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module   : div_ratio_monitor
// Purpose  : Measures period and high time of a divided clock in master-clock
//            cycles, tracks lock against the expected ratio, flags errors.
// Revision : 1.0 - initial release
// ============================================================================
module div_ratio_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int EXP_RATIO = 4,
    parameter int LOCK_CNT  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_clk_i,
    input  logic             clr_err_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] low_o,
    output logic             period_vld_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             stall_o
);

    localparam int               MC_W       = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_SAT      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_PRE_SAT  = c_SAT - c_ONE;
    localparam logic [CNT_W-1:0] c_EXP      = CNT_W'(EXP_RATIO);
    localparam logic [MC_W-1:0]  c_LAST_MC  = MC_W'(LOCK_CNT - 1);

    logic                 w_rise;
    logic                 w_lvl;
    logic                 w_match;
    logic                 w_measure;
    logic                 w_stall;
    logic                 w_err_set;
    div_mon_state_e       w_state_nxt;
    logic [MC_W-1:0]      w_match_cnt_nxt;

    div_mon_state_e       r_state;
    logic [MC_W-1:0]      r_match_cnt;
    logic [CNT_W-1:0]     r_per_cnt;
    logic [CNT_W-1:0]     r_hi_cnt;
    logic [CNT_W-1:0]     r_period;
    logic [CNT_W-1:0]     r_high;
    logic [CNT_W-1:0]     r_low;
    logic                 r_vld;
    logic                 r_locked;
    logic                 r_err;
    logic                 r_stall;

    rise_detect u_rise_detect (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (div_clk_i),
        .rise_o (w_rise),
        .lvl_o  (w_lvl)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_rise) begin
            r_per_cnt <= c_ONE;
            r_hi_cnt  <= c_ONE;
        end else begin
            if (r_per_cnt != c_SAT) begin
                r_per_cnt <= r_per_cnt + c_ONE;
            end
            if (w_lvl && (r_hi_cnt != c_SAT)) begin
                r_hi_cnt <= r_hi_cnt + c_ONE;
            end
        end
    end

    // A saturated period can never equal the expected ratio, so it always mismatches.
    assign w_match   = (r_per_cnt == c_EXP) && duty_match(32'(r_hi_cnt), 32'(EXP_RATIO));
    assign w_measure = w_rise && (r_state != IDLE);
    assign w_stall   = !w_rise && (r_per_cnt == c_PRE_SAT) && (r_state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_err_set       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt     = ACQUIRE;
                    w_match_cnt_nxt = '0;
                end
            end
            ACQUIRE: begin
                if (w_stall) begin
                    w_state_nxt     = IDLE;
                    w_match_cnt_nxt = '0;
                end else if (w_rise) begin
                    if (!w_match) begin
                        w_match_cnt_nxt = '0;
                    end else if (r_match_cnt == c_LAST_MC) begin
                        w_state_nxt     = LOCKED;
                        w_match_cnt_nxt = '0;
                    end else begin
                        w_match_cnt_nxt = r_match_cnt + MC_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (w_stall) begin
                    w_state_nxt     = IDLE;
                    w_match_cnt_nxt = '0;
                    w_err_set       = 1'b1;
                end else if (w_rise && !w_match) begin
                    w_state_nxt     = ACQUIRE;
                    w_match_cnt_nxt = '0;
                    w_err_set       = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_match_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_match_cnt <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_low       <= '0;
            r_vld       <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_match_cnt <= w_match_cnt_nxt;
            r_vld       <= w_measure;
            r_stall     <= w_stall;
            r_locked    <= (w_state_nxt == LOCKED);
            if (w_measure) begin
                r_period <= r_per_cnt;
                r_high   <= r_hi_cnt;
                r_low    <= r_per_cnt - r_hi_cnt;
            end
            // A new error outranks a simultaneous clear so it is never lost.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (clr_err_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign period_o     = r_period;
    assign high_o       = r_high;
    assign low_o        = r_low;
    assign period_vld_o = r_vld;
    assign locked_o     = r_locked;
    assign err_o        = r_err;
    assign stall_o      = r_stall;

endmodule : div_ratio_monitor
`default_nettype wire

// File: tb/tb_div_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ratio_monitor
// Purpose  : Directed self-checking bench for div_ratio_monitor (ratio 4, lock 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ratio_monitor;

    localparam int CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             div_clk_i;
    logic             clr_err_i;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] low_o;
    logic             period_vld_o;
    logic             locked_o;
    logic             err_o;
    logic             stall_o;

    int n_chk  = 0;
    int n_fail = 0;

    int nv, v_per, v_hi, v_lo, v_lock, v_err, n_stall;
    int stall_k, st_lock, st_err, hold_vld;

    div_ratio_monitor #(
        .CNT_W     (CNT_W),
        .EXP_RATIO (4),
        .LOCK_CNT  (3)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .div_clk_i    (div_clk_i),
        .clr_err_i    (clr_err_i),
        .period_o     (period_o),
        .high_o       (high_o),
        .low_o        (low_o),
        .period_vld_o (period_vld_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .stall_o      (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One source period: hi cycles high then lo cycles low; clr_err_i on tick clr_at.
    task automatic drive_period(input int hi, input int lo, input int clr_at);
        nv = 0;
        for (int t = 0; t < hi + lo; t++) begin
            div_clk_i = (t < hi);
            clr_err_i = (t == clr_at);
            @(posedge clk_i);
            #1;
            if (period_vld_o) begin
                nv++;
                v_per  = int'(period_o);
                v_hi   = int'(high_o);
                v_lo   = int'(low_o);
                v_lock = int'(locked_o);
                v_err  = int'(err_o);
            end
            if (stall_o) n_stall++;
        end
        clr_err_i = 1'b0;
    endtask

    task automatic expect_meas(input string tag, input int per, input int hi,
                               input int lock, input int err);
        chk({tag, " vld"}, nv, 1);
        chk({tag, " period"}, v_per, per);
        chk({tag, " high"}, v_hi, hi);
        chk({tag, " low"}, v_lo, per - hi);
        chk({tag, " locked"}, v_lock, lock);
        chk({tag, " err"}, v_err, err);
    endtask

    task automatic pulse_reset(input string tag);
        rst_i     = 1'b1;
        div_clk_i = 1'b0;
        clr_err_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk({tag, " outputs"},
            int'({period_o, high_o, low_o, period_vld_o, locked_o, err_o, stall_o}), 0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        div_clk_i = 1'b0;
        clr_err_i = 1'b0;
        n_stall   = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset outputs",
            int'({period_o, high_o, low_o, period_vld_o, locked_o, err_o, stall_o}), 0);
        rst_i = 1'b0;

        // Free-running divide-by-4: arm, then lock on the third measurement
        drive_period(2, 2, -1);
        chk("arm no vld", nv, 0);
        for (int i = 1; i <= 4; i++) begin
            drive_period(2, 2, -1);
            expect_meas($sformatf("run%0d", i), 4, 2, (i >= 3) ? 1 : 0, 0);
        end

        // Switch to period 3: first rise still reports the old period
        drive_period(2, 1, -1);
        expect_meas("p3 first", 4, 2, 1, 0);
        drive_period(2, 1, -1);
        expect_meas("p3 lose", 3, 2, 0, 1);
        drive_period(2, 2, -1);
        expect_meas("back4 a", 3, 2, 0, 1);
        for (int j = 1; j <= 3; j++) begin
            drive_period(2, 2, -1);
            expect_meas($sformatf("relock%0d", j), 4, 2, (j == 3) ? 1 : 0, 1);
        end

        // Clear error, then clear colliding with a locked mismatch
        drive_period(2, 2, 0);
        expect_meas("clr", 4, 2, 1, 0);
        drive_period(2, 1, -1);
        expect_meas("pre collide", 4, 2, 1, 0);
        drive_period(2, 1, 2);
        expect_meas("collide", 3, 2, 0, 1);
        drive_period(2, 2, -1);
        expect_meas("post collide", 3, 2, 0, 1);
        for (int j = 1; j <= 3; j++) begin
            drive_period(2, 2, (j == 1) ? 0 : -1);
            expect_meas($sformatf("relock2_%0d", j), 4, 2, (j == 3) ? 1 : 0, 0);
        end

        // Stall while locked: per_cnt is 2 after the last period, 255 after 253 more cycles
        n_stall  = 0;
        stall_k  = -1;
        st_lock  = -1;
        st_err   = -1;
        hold_vld = 0;
        for (int k = 1; k <= 300; k++) begin
            div_clk_i = 1'b0;
            @(posedge clk_i);
            #1;
            if (period_vld_o) hold_vld++;
            if (stall_o) begin
                n_stall++;
                stall_k = k;
                st_lock = int'(locked_o);
                st_err  = int'(err_o);
            end
        end
        chk("stall count", n_stall, 1);
        chk("stall cycle", stall_k, 253);
        chk("stall locked", st_lock, 0);
        chk("stall err", st_err, 1);
        chk("stall vld", hold_vld, 0);
        drive_period(2, 2, 0);
        chk("post-stall arm vld", nv, 0);
        chk("post-stall err clr", int'(err_o), 0);
        for (int j = 1; j <= 3; j++) begin
            drive_period(2, 2, -1);
            expect_meas($sformatf("stall relock%0d", j), 4, 2, (j == 3) ? 1 : 0, 0);
        end

        // Reset while locked, then relock from scratch
        pulse_reset("mid reset");
        drive_period(2, 2, -1);
        chk("reset arm vld", nv, 0);
        for (int j = 1; j <= 3; j++) begin
            drive_period(2, 2, -1);
            expect_meas($sformatf("reset relock%0d", j), 4, 2, (j == 3) ? 1 : 0, 0);
        end

        // Wrong duty cycle: period 4, high 1 never locks
        pulse_reset("duty reset");
        drive_period(1, 3, -1);
        chk("duty arm vld", nv, 0);
        for (int j = 1; j <= 4; j++) begin
            drive_period(1, 3, -1);
            expect_meas($sformatf("duty%0d", j), 4, 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_div_ratio_monitor
`default_nettype wire
